// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with two write ports, write-to-read bypass and clear sweep
//
// Purpose:
//   DEPTH = 2**ADDR_W entries of DATA_W bits. NREAD registered read ports and
//   two write ports. A read in the same cycle as a write returns the new value.
//   Entry 0 can be hardwired to zero. The storage has no reset. Instead a
//   clear sweep zeroes one entry per cycle after reset or on an i_clr request.
//
// Ports:
//   i_clk   clock, all state updates on posedge
//   i_rst   asynchronous active-high reset (clears rd, starts a sweep)
//   i_clr   request a clear sweep (accepted only while idle)
//   o_busy  clear sweep in progress; writes dropped, reads return 0
//   i_ra    read addresses, port k at [k*ADDR_W +: ADDR_W]
//   o_rd    registered read data, port k at [k*DATA_W +: DATA_W]
//   i_we0/i_wa0/i_wd0  write port 0
//   i_we1/i_wa1/i_wd1  write port 1 (wins on an address collision)

`timescale 1ns/1ps

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  output logic                     o_busy,
  input  logic [NREAD*ADDR_W-1:0]  i_ra,
  output logic [NREAD*DATA_W-1:0]  o_rd,
  input  logic                     i_we0,
  input  logic [ADDR_W-1:0]        i_wa0,
  input  logic [DATA_W-1:0]        i_wd0,
  input  logic                     i_we1,
  input  logic [ADDR_W-1:0]        i_wa1,
  input  logic [DATA_W-1:0]        i_wd1
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic                      w_busy;
  logic [ADDR_W-1:0]         r_cnt;
  logic [DATA_W-1:0]         r_mem [DEPTH];
  logic [NREAD*DATA_W-1:0]   r_rd;
  logic [NREAD*DATA_W-1:0]   w_rd_nxt;
  logic [ADDR_W-1:0]         w_addr;
  logic                      w_wr0;
  logic                      w_wr1;

  // ---------------------------------------------------------------------------
  // Clear FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Clear FSM: next state. The last entry is written on the edge that
  // returns to idle, so busy drops on that same edge.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_clr) w_next_state = S_CLEAR;
      S_CLEAR: if (r_cnt == ADDR_W'(DEPTH - 1)) w_next_state = S_IDLE;
      default: w_next_state = S_CLEAR;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_CLEAR: w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  assign o_busy = w_busy;

  // Sweep counter. It wraps to 0 when the sweep ends, so it already holds 0
  // when the next request arrives. Loading it explicitly keeps that visible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_cnt <= r_cnt + ADDR_W'(1);
    end else if (i_clr) begin
      r_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: no reset. The sweep owns the array while busy.
  // ---------------------------------------------------------------------------
  assign w_wr0 = i_we0 && !(ZERO_EN && (i_wa0 == '0));
  assign w_wr1 = i_we1 && !(ZERO_EN && (i_wa1 == '0));

  // Port 1 is written last, so it wins when both ports hit the same entry.
  always_ff @(posedge i_clk) begin
    if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_wr0) r_mem[i_wa0] <= i_wd0;
      if (w_wr1) r_mem[i_wa1] <= i_wd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: per-port bypass selection, then a register stage
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_nxt = '0;
    w_addr   = '0;
    for (int k = 0; k < NREAD; k++) begin
      w_addr = i_ra[k*ADDR_W +: ADDR_W];
      if (w_busy) begin
        w_rd_nxt[k*DATA_W +: DATA_W] = '0;
      end else if (ZERO_EN && (w_addr == '0)) begin
        w_rd_nxt[k*DATA_W +: DATA_W] = '0;
      end else if (i_we1 && (i_wa1 == w_addr)) begin
        w_rd_nxt[k*DATA_W +: DATA_W] = i_wd1;
      end else if (i_we0 && (i_wa0 == w_addr)) begin
        w_rd_nxt[k*DATA_W +: DATA_W] = i_wd0;
      end else begin
        w_rd_nxt[k*DATA_W +: DATA_W] = r_mem[w_addr];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd <= '0;
    end else begin
      r_rd <= w_rd_nxt;
    end
  end

  assign o_rd = r_rd;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp against an array reference model

`timescale 1ns/1ps

module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [9:0]  ra;
  logic        we0;
  logic [4:0]  wa0;
  logic [31:0] wd0;
  logic        we1;
  logic [4:0]  wa1;
  logic [31:0] wd1;
  logic        busy;
  logic [63:0] rd;
  logic        busy_nz;
  logic [63:0] rd_nz;

  int n_vec;
  int n_err;

  // Reference model: the array contents seen by each configuration, and how
  // many more edges the clear sweep keeps the file busy.
  logic [31:0] m_z  [32];
  logic [31:0] m_nz [32];
  int          m_busy_left;
  logic [31:0] exp_z  [2];
  logic [31:0] exp_nz [2];

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_busy(busy),
    .i_ra(ra), .o_rd(rd),
    .i_we0(we0), .i_wa0(wa0), .i_wd0(wd0),
    .i_we1(we1), .i_wa1(wa1), .i_wd1(wd1)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(0)) u_dut_nz (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_busy(busy_nz),
    .i_ra(ra), .o_rd(rd_nz),
    .i_we0(we0), .i_wa0(wa0), .i_wd0(wd0),
    .i_we1(we1), .i_wa1(wa1), .i_wd1(wd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input bit zero, input logic [4:0] a);
    if (zero && a == 5'd0) return 32'h0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return zero ? m_z[a] : m_nz[a];
  endfunction

  task automatic model_reset();
    m_busy_left = 32;
    for (int i = 0; i < 32; i++) begin
      m_z[i]  = 32'h0;
      m_nz[i] = 32'h0;
    end
    for (int k = 0; k < 2; k++) begin
      exp_z[k]  = 32'h0;
      exp_nz[k] = 32'h0;
    end
  endtask

  // Advance one clock edge and update the model with that edge's effects.
  task automatic tick();
    logic [4:0] a;
    for (int k = 0; k < 2; k++) begin
      a = ra[k*5 +: 5];
      if (m_busy_left > 0) begin
        exp_z[k]  = 32'h0;
        exp_nz[k] = 32'h0;
      end else begin
        exp_z[k]  = model_read(1'b1, a);
        exp_nz[k] = model_read(1'b0, a);
      end
    end
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else begin
      if (we0) begin
        if (wa0 != 5'd0) m_z[wa0] = wd0;
        m_nz[wa0] = wd0;
      end
      if (we1) begin
        if (wa1 != 5'd0) m_z[wa1] = wd1;
        m_nz[wa1] = wd1;
      end
      if (clr) begin
        m_busy_left = 32;
        for (int i = 0; i < 32; i++) begin
          m_z[i]  = 32'h0;
          m_nz[i] = 32'h0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; we0 = 1'b0; we1 = 1'b0;
    wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'h0; wd1 = 32'h0; ra = 10'd0;
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (rd !== 64'h0 || busy !== 1'b1 || rd_nz !== 64'h0 || busy_nz !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state rd=%h busy=%b rd_nz=%h busy_nz=%b, want rd=0 busy=1", rd, busy, rd_nz, busy_nz);
    end
    rst = 1'b0;
    model_reset();
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    n_vec++;
    if (n != 32 || busy_nz !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sweep_len got %0d busy_nz=%b, want 32 and 0", n, busy_nz);
    end
  endtask

  task automatic test_reset_clears_preload();
    int n;
    for (int a = 0; a < 32; a += 2) begin
      we0 = 1'b1; wa0 = 5'(a);     wd0 = 32'hDEADBEEF;
      we1 = 1'b1; wa1 = 5'(a + 1); wd1 = 32'hDEADBEEF;
      tick();
    end
    idle_inputs();
    ra = {5'd17, 5'd4};
    tick();
    n_vec++;
    if (rd_nz[31:0] !== 32'hDEADBEEF || rd[63:32] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL preload rd_nz0=%h rd1=%h, want deadbeef", rd_nz[31:0], rd[63:32]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    n_vec++;
    if (n != 32) begin
      n_err++;
      $display("FAIL preload_sweep_len got %0d want 32", n);
    end
    for (int a = 0; a < 32; a++) begin
      ra = {5'(a + 16), 5'(a)};
      tick();
      n_vec++;
      if (rd !== 64'h0 || rd_nz !== 64'h0) begin
        n_err++;
        $display("FAIL swept_read addr=%0d rd=%h rd_nz=%h want 0", a, rd, rd_nz);
      end
    end
  endtask

  task automatic test_basic_rw();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h12345678; ra = 10'd0;
    tick();
    we0 = 1'b0;
    ra = {5'd6, 5'd5};
    tick();
    n_vec++;
    if (rd[31:0] !== 32'h12345678 || rd[63:32] !== 32'h0) begin
      n_err++;
      $display("FAIL basic_rw rd0=%h rd1=%h want 12345678/0", rd[31:0], rd[63:32]);
    end
    // Single-port bypass on port 1 while port 0 reads the stored entry.
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hCAFE0009; ra = {5'd9, 5'd5};
    tick();
    we0 = 1'b0;
    n_vec++;
    if (rd[63:32] !== 32'hCAFE0009 || rd[31:0] !== 32'h12345678) begin
      n_err++;
      $display("FAIL bypass_wp0 rd1=%h rd0=%h want cafe0009/12345678", rd[63:32], rd[31:0]);
    end
  endtask

  task automatic test_bypass_conflict();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA0000;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h5555FFFF;
    ra = {5'd7, 5'd7};
    tick();
    n_vec++;
    if (rd[31:0] !== 32'h5555FFFF || rd[63:32] !== 32'h5555FFFF) begin
      n_err++;
      $display("FAIL conflict_bypass rd0=%h rd1=%h want 5555ffff", rd[31:0], rd[63:32]);
    end
    we0 = 1'b0; we1 = 1'b0;
    tick();
    n_vec++;
    if (rd[31:0] !== 32'h5555FFFF || rd_nz[63:32] !== 32'h5555FFFF) begin
      n_err++;
      $display("FAIL conflict_stored rd0=%h rd_nz1=%h want 5555ffff", rd[31:0], rd_nz[63:32]);
    end
  endtask

  task automatic test_zero_reg();
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; ra = {5'd7, 5'd0};
    tick();
    n_vec++;
    if (rd[31:0] !== 32'h0 || rd_nz[31:0] !== 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL zero_bypass rd0=%h rd_nz0=%h want 0/ffffffff", rd[31:0], rd_nz[31:0]);
    end
    we1 = 1'b0;
    tick();
    n_vec++;
    if (rd[31:0] !== 32'h0 || rd_nz[31:0] !== 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL zero_stored rd0=%h rd_nz0=%h want 0/ffffffff", rd[31:0], rd_nz[31:0]);
    end
  endtask

  task automatic test_async_reset();
    int n;
    ra = {5'd7, 5'd7};
    tick();
    rst = 1'b1;
    #2;
    n_vec++;
    if (rd !== 64'h0 || rd_nz !== 64'h0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset rd=%h rd_nz=%h busy=%b want 0/0/1", rd, rd_nz, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    n_vec++;
    if (n != 32) begin
      n_err++;
      $display("FAIL async_reset_sweep got %0d want 32", n);
    end
  endtask

  task automatic test_soft_clear();
    int n;
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i);
      tick();
    end
    we0 = 1'b0;
    ra = {5'd3, 5'd31};
    tick();
    n_vec++;
    if (rd[31:0] !== 32'd31 || rd[63:32] !== 32'd3) begin
      n_err++;
      $display("FAIL fill rd0=%h rd1=%h want 1f/3", rd[31:0], rd[63:32]);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      we0 = (n == 2); wa0 = 5'd3; wd0 = 32'h33333333;
      clr = (n == 15);
      ra  = {5'd3, 5'd3};
      tick();
      n++;
      n_vec++;
      if (rd !== 64'h0) begin
        n_err++;
        $display("FAIL clear_read cycle=%0d rd=%h want 0", n, rd);
      end
    end
    idle_inputs();
    n_vec++;
    if (n != 32) begin
      n_err++;
      $display("FAIL clear_len got %0d want 32", n);
    end
    for (int a = 0; a < 32; a += 2) begin
      ra = {5'(a + 1), 5'(a)};
      tick();
      n_vec++;
      if (rd !== 64'h0 || rd_nz !== 64'h0) begin
        n_err++;
        $display("FAIL cleared_read addr=%0d rd=%h rd_nz=%h want 0", a, rd, rd_nz);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #2;
    n_vec++;
    if (rd !== 64'h0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_sweep_reset rd=%h busy=%b want 0/1", rd, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    n_vec++;
    if (n != 32) begin
      n_err++;
      $display("FAIL mid_sweep_len got %0d want 32", n);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = 5'($urandom_range(0, 7));
      wa1 = 5'($urandom_range(0, 7));
      wd0 = $urandom();
      wd1 = $urandom();
      ra  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      clr = ($urandom_range(0, 99) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (rd[k*32 +: 32] !== exp_z[k]) begin
          n_err++;
          $display("FAIL rand_z cyc=%0d port=%0d got %h want %h", c, k, rd[k*32 +: 32], exp_z[k]);
        end
        n_vec++;
        if (rd_nz[k*32 +: 32] !== exp_nz[k]) begin
          n_err++;
          $display("FAIL rand_nz cyc=%0d port=%0d got %h want %h", c, k, rd_nz[k*32 +: 32], exp_nz[k]);
        end
      end
      n_vec++;
      if (busy !== (m_busy_left > 0) || busy_nz !== (m_busy_left > 0)) begin
        n_err++;
        $display("FAIL rand_busy cyc=%0d got %b/%b want %b", c, busy, busy_nz, m_busy_left > 0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_reset_clears_preload();
    test_basic_rw();
    test_bypass_conflict();
    test_zero_reg();
    test_async_reset();
    test_soft_clear();
    test_reset_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
